// File: rtl/mem_request_master_if.sv
// Signal bundle between the CPU-side command/response port, the memory request
// master and the memory controller.
interface mem_request_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        request;
  logic        request_type;
  logic [15:0] request_address;
  logic [15:0] data_out;
  logic [15:0] memory_in;
  logic        memory_ready;
  logic        write_complete;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  memory_in, memory_ready, write_complete,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy,
    output request, request_type, request_address, data_out
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output memory_in, memory_ready, write_complete,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy,
    input  request, request_type, request_address, data_out
  );
endinterface

// File: rtl/mem_request_master.sv
// Queues CPU load/store commands, issues one-cycle request pulses to the memory
// controller, and returns one response per command (error on watchdog expiry).
module mem_request_master #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_request_master_if.master bus,
  output logic [1:0]           state_dbg
);

  // Command side: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // the CPU must hold the command stable until then. Responses are one-cycle
  // rsp_valid pulses with no backpressure.

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [32:0]     fifo_mem [CMD_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            done;

  logic            request_q;
  logic            req_type_q;
  logic [15:0]     req_addr_q;
  logic [15:0]     data_out_q;
  logic            rsp_valid_q;
  logic            rsp_write_q;
  logic [15:0]     rsp_rdata_q;
  logic            rsp_error_q;

  assign full  = (count == CW'(CMD_DEPTH));
  assign empty = (count == '0);
  // No push-through: a full FIFO refuses even when a pop happens this cycle.
  assign push  = bus.cmd_valid && !full && !reset;
  assign pop   = (state == IDLE) && !empty;
  // Only the flag matching the outstanding command counts as completion.
  assign done  = req_type_q ? bus.write_complete : bus.memory_ready;

  assign bus.cmd_ready       = !full && !reset;
  assign bus.busy            = !empty || (state != IDLE);
  assign bus.request         = request_q;
  assign bus.request_type    = req_type_q;
  assign bus.request_address = req_addr_q;
  assign bus.data_out        = data_out_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_write       = rsp_write_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_error       = rsp_error_q;
  assign state_dbg           = state;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      request_q   <= 1'b0;
      req_type_q  <= 1'b0;
      req_addr_q  <= '0;
      data_out_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            {req_type_q, req_addr_q, data_out_q} <= fifo_mem[rd_ptr];
            request_q <= 1'b1;
            state     <= ISSUE;
          end else begin
            request_q <= 1'b0;
          end
        end
        ISSUE: begin
          request_q <= 1'b0;
          timer     <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // Completion is tested first so it wins over a simultaneous timeout.
          if (done) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= req_type_q;
            rsp_rdata_q <= req_type_q ? 16'h0000 : bus.memory_in;
            rsp_error_q <= 1'b0;
            state       <= IDLE;
          end else if (timer == TIMER_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= req_type_q;
            rsp_rdata_q <= 16'h0000;
            rsp_error_q <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_master.sv
// Directed bench for mem_request_master with a small memory-controller model.
module tb_mem_request_master;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  mem_request_master_if bus();

  mem_request_master #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory controller model: latches on the request edge, clears its flags,
  // raises the matching flag 'delay' edges later (delay from delay_q, default 1).
  logic [15:0] mem_arr [0:255];
  int          pend = 0;
  logic        l_type = 1'b0;
  logic [15:0] l_addr = '0;
  int          delay_q[$];
  logic        manual = 1'b0;
  logic        man_mr = 1'b0;
  logic        man_wc = 1'b0;
  logic [15:0] man_data = '0;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    bus.memory_ready   = 1'b0;
    bus.write_complete = 1'b0;
    bus.memory_in      = '0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_write      = 1'b0;
    bus.cmd_addr       = '0;
    bus.cmd_wdata      = '0;
  end

  always @(posedge clk) begin : mem_model
    int d;
    if (manual) begin
      bus.memory_ready   <= man_mr;
      bus.write_complete <= man_wc;
      bus.memory_in      <= man_data;
    end else if (bus.request) begin
      d = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
      l_type <= bus.request_type;
      l_addr <= bus.request_address;
      if (bus.request_type) mem_arr[bus.request_address[7:0]] <= bus.data_out;
      bus.memory_ready   <= 1'b0;
      bus.write_complete <= 1'b0;
      pend <= d;
    end else if (pend == 1) begin
      if (l_type) bus.write_complete <= 1'b1;
      else begin
        bus.memory_ready <= 1'b1;
        bus.memory_in    <= mem_arr[l_addr[7:0]];
      end
      pend <= 0;
    end else if (pend > 1) begin
      pend <= pend - 1;
    end
  end

  // Observation logs, sampled on the falling edge.
  logic [17:0] rsp_q[$];
  int          rsp_cyc_q[$];
  logic [32:0] req_q[$];
  int          req_cyc_q[$];
  int          dbl_req = 0;
  logic        prev_req = 1'b0;
  logic [17:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      rsp_q.push_back({bus.rsp_write, bus.rsp_error, bus.rsp_rdata});
      rsp_cyc_q.push_back(cyc);
    end
    if (bus.request) begin
      req_q.push_back({bus.request_type, bus.request_address, bus.data_out});
      req_cyc_q.push_back(cyc);
      if (prev_req) dbl_req++;
    end
    prev_req = bus.request;
  end

  task automatic clear_logs();
    rsp_q.delete(); rsp_cyc_q.delete(); req_q.delete(); req_cyc_q.delete();
    exp_q.delete(); dbl_req = 0;
  endtask

  task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d,
                      output logic was_ready);
    int n;
    n = 0;
    was_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 200) begin
      was_ready = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL push_accept: cmd_ready stuck low got 0 want 1");
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string name);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (rsp_q.size() < n) begin
      n_cmp++; n_err++;
      $display("FAIL %s_wait: responses got %0d want %0d", name, rsp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.busy, bus.request, bus.request_type, bus.rsp_valid,
         bus.rsp_write, bus.rsp_error} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000000", {bus.cmd_ready, bus.busy,
               bus.request, bus.request_type, bus.rsp_valid, bus.rsp_write, bus.rsp_error});
    end
    n_cmp++;
    if ({bus.request_address, bus.data_out, bus.rsp_rdata} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {bus.request_address, bus.data_out, bus.rsp_rdata});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.cmd_ready, bus.busy, state_dbg} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_release: ready/busy/state got %b want 1000", {bus.cmd_ready, bus.busy, state_dbg});
    end
  endtask

  task automatic test_write_read();
    logic r;
    logic [17:0] got;
    clear_logs();
    push(1'b1, 16'h0010, 16'hBEEF, r);
    push(1'b0, 16'h0010, 16'h0000, r);
    wait_rsp(2, "wr");
    repeat (6) @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 16'h0000});
    exp_q.push_back({1'b0, 1'b0, 16'hBEEF});
    for (int i = 0; i < 2; i++) begin
      got = (i < rsp_q.size()) ? rsp_q[i] : 18'h3FFFF;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL wr_rsp%0d: got %h want %h", i, got, exp_q[i]);
      end
    end
    n_cmp++;
    if (rsp_q.size() != 2 || req_q.size() != 2 || (req_cyc_q[1] - req_cyc_q[0]) != 4 ||
        (rsp_cyc_q[1] - rsp_cyc_q[0]) != 4) begin
      n_err++;
      $display("FAIL wr_spacing: rsp=%0d req=%0d want 2/2, 4 cycles apart", rsp_q.size(), req_q.size());
    end
    n_cmp++;
    if (req_q.size() < 1 || req_q[0] !== {1'b1, 16'h0010, 16'hBEEF}) begin
      n_err++;
      $display("FAIL wr_request_fields: got %h want %h", (req_q.size() > 0) ? req_q[0] : 33'h0,
               {1'b1, 16'h0010, 16'hBEEF});
    end
    n_cmp++;
    if (rsp_cyc_q.size() > 0 && req_cyc_q.size() > 0 && (rsp_cyc_q[0] - req_cyc_q[0]) != 3) begin
      n_err++;
      $display("FAIL wr_latency: got %0d want 3", rsp_cyc_q[0] - req_cyc_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic r, all_ready;
    logic [17:0] got;
    clear_logs();
    all_ready = 1'b1;
    push(1'b1, 16'h0020, 16'h1111, r); all_ready &= r;
    push(1'b1, 16'h0021, 16'h2222, r); all_ready &= r;
    push(1'b0, 16'h0020, 16'h0000, r); all_ready &= r;
    push(1'b0, 16'h0021, 16'h0000, r); all_ready &= r;
    wait_rsp(4, "b2b");
    n_cmp++;
    if (all_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready: got %b want 1", all_ready);
    end
    exp_q.push_back({1'b1, 1'b0, 16'h0000});
    exp_q.push_back({1'b1, 1'b0, 16'h0000});
    exp_q.push_back({1'b0, 1'b0, 16'h1111});
    exp_q.push_back({1'b0, 1'b0, 16'h2222});
    for (int i = 0; i < 4; i++) begin
      got = (i < rsp_q.size()) ? rsp_q[i] : 18'h3FFFF;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_rsp%0d: got %h want %h", i, got, exp_q[i]);
      end
    end
    for (int i = 1; i < rsp_cyc_q.size(); i++) begin
      n_cmp++;
      if (rsp_cyc_q[i] - rsp_cyc_q[i-1] != 4) begin
        n_err++;
        $display("FAIL b2b_gap%0d: got %0d want 4", i, rsp_cyc_q[i] - rsp_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_stall();
    logic r, stalled;
    logic [17:0] got;
    clear_logs();
    stalled = 1'b0;
    repeat (6) delay_q.push_back(6);
    push(1'b0, 16'h0020, 16'h0000, r); stalled |= !r;
    push(1'b0, 16'h0021, 16'h0000, r); stalled |= !r;
    push(1'b1, 16'h0030, 16'h3333, r); stalled |= !r;
    push(1'b0, 16'h0030, 16'h0000, r); stalled |= !r;
    push(1'b0, 16'h0010, 16'h0000, r); stalled |= !r;
    push(1'b1, 16'h0031, 16'h4444, r); stalled |= !r;
    wait_rsp(6, "stall");
    repeat (4) @(negedge clk);
    n_cmp++;
    if (stalled !== 1'b1) begin
      n_err++;
      $display("FAIL stall_ready_drop: got %b want 1", stalled);
    end
    exp_q.push_back({1'b0, 1'b0, 16'h1111});
    exp_q.push_back({1'b0, 1'b0, 16'h2222});
    exp_q.push_back({1'b1, 1'b0, 16'h0000});
    exp_q.push_back({1'b0, 1'b0, 16'h3333});
    exp_q.push_back({1'b0, 1'b0, 16'hBEEF});
    exp_q.push_back({1'b1, 1'b0, 16'h0000});
    for (int i = 0; i < 6; i++) begin
      got = (i < rsp_q.size()) ? rsp_q[i] : 18'h3FFFF;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL stall_rsp%0d: got %h want %h", i, got, exp_q[i]);
      end
    end
    n_cmp++;
    if (rsp_q.size() != 6 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_count: got %0d busy %b want 6 busy 0", rsp_q.size(), bus.busy);
    end
  endtask

  task automatic test_timeout();
    logic r;
    logic [17:0] got;
    clear_logs();
    delay_q.push_back(8);
    delay_q.push_back(1);
    push(1'b0, 16'h0020, 16'h0000, r);
    push(1'b0, 16'h0021, 16'h0000, r);
    wait_rsp(2, "tmo");
    repeat (10) @(negedge clk);
    exp_q.push_back({1'b0, 1'b1, 16'h0000});
    exp_q.push_back({1'b0, 1'b0, 16'h2222});
    for (int i = 0; i < 2; i++) begin
      got = (i < rsp_q.size()) ? rsp_q[i] : 18'h3FFFF;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL tmo_rsp%0d: got %h want %h", i, got, exp_q[i]);
      end
    end
    n_cmp++;
    if (rsp_q.size() != 2) begin
      n_err++;
      $display("FAIL tmo_count: got %0d want 2", rsp_q.size());
    end
    n_cmp++;
    if (rsp_cyc_q.size() > 0 && req_cyc_q.size() > 0 && (rsp_cyc_q[0] - req_cyc_q[0]) != 9) begin
      n_err++;
      $display("FAIL tmo_latency: got %0d want 9", rsp_cyc_q[0] - req_cyc_q[0]);
    end
  endtask

  task automatic test_completion_at_expiry();
    logic r;
    logic [17:0] got;
    clear_logs();
    delay_q.push_back(7);
    push(1'b0, 16'h0021, 16'h0000, r);
    wait_rsp(1, "edge");
    got = (rsp_q.size() > 0) ? rsp_q[0] : 18'h3FFFF;
    n_cmp++;
    if (got !== {1'b0, 1'b0, 16'h2222}) begin
      n_err++;
      $display("FAIL edge_rsp: got %h want %h", got, {1'b0, 1'b0, 16'h2222});
    end
    n_cmp++;
    if (rsp_cyc_q.size() > 0 && req_cyc_q.size() > 0 && (rsp_cyc_q[0] - req_cyc_q[0]) != 9) begin
      n_err++;
      $display("FAIL edge_latency: got %0d want 9", rsp_cyc_q[0] - req_cyc_q[0]);
    end
  endtask

  task automatic test_wrong_flag();
    logic r;
    logic [17:0] got;
    int k;
    clear_logs();
    manual = 1'b1;
    push(1'b0, 16'h0040, 16'h0000, r);
    k = 0;
    while (state_dbg !== 2'd2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    man_wc = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (rsp_q.size() != 0 || state_dbg !== 2'd2) begin
      n_err++;
      $display("FAIL wrong_flag_ignored: rsp=%0d state=%0d want 0 and 2", rsp_q.size(), state_dbg);
    end
    man_wc = 1'b0;
    man_mr = 1'b1;
    man_data = 16'h1234;
    wait_rsp(1, "wrong_flag");
    man_mr = 1'b0;
    repeat (2) @(negedge clk);
    manual = 1'b0;
    got = (rsp_q.size() > 0) ? rsp_q[0] : 18'h3FFFF;
    n_cmp++;
    if (got !== {1'b0, 1'b0, 16'h1234}) begin
      n_err++;
      $display("FAIL wrong_flag_rsp: got %h want %h", got, {1'b0, 1'b0, 16'h1234});
    end
  endtask

  task automatic test_reset_in_wait();
    logic r;
    int k;
    clear_logs();
    delay_q.push_back(20);
    push(1'b0, 16'h0020, 16'h0000, r);
    push(1'b0, 16'h0021, 16'h0000, r);
    push(1'b0, 16'h0010, 16'h0000, r);
    k = 0;
    while (state_dbg !== 2'd2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.cmd_ready, bus.busy, bus.request, bus.request_type, bus.rsp_valid,
         bus.rsp_write, bus.rsp_error, state_dbg} !== 9'b0 ||
        {bus.request_address, bus.data_out, bus.rsp_rdata} !== 48'h0) begin
      n_err++;
      $display("FAIL async_reset: flags %b data %h want all 0", {bus.cmd_ready, bus.busy,
               bus.request, bus.rsp_valid, state_dbg}, {bus.request_address, bus.data_out, bus.rsp_rdata});
    end
    @(negedge clk);
    reset = 1'b0;
    delay_q.delete();
    clear_logs();
    repeat (25) @(negedge clk);
    n_cmp++;
    if (rsp_q.size() != 0 || req_q.size() != 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_quiet: rsp=%0d req=%0d busy=%b want 0 0 0", rsp_q.size(), req_q.size(), bus.busy);
    end
  endtask

  int total_dbl = 0;

  initial begin
    test_reset();
    test_write_read();
    total_dbl += dbl_req;
    test_back_to_back();
    total_dbl += dbl_req;
    test_stall();
    total_dbl += dbl_req;
    test_timeout();
    total_dbl += dbl_req;
    test_completion_at_expiry();
    total_dbl += dbl_req;
    test_wrong_flag();
    total_dbl += dbl_req;
    n_cmp++;
    if (total_dbl != 0) begin
      n_err++;
      $display("FAIL request_single_cycle: got %0d double pulses want 0", total_dbl);
    end
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish want finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_request_master.md
Name: mem_request_master

Overview:
- Initiator side of the memory request interface: turns CPU-side load/store commands into single-cycle `request` pulses toward `memory_control`.
- Waits for `memory_ready` (read) or `write_complete` (write), then returns one response per command.
- Contains a small command FIFO so the CPU can queue accesses while one is in flight.
- Contains a watchdog timer, so a lost completion produces an error response instead of a hang.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 8, maximum cycles spent in WAIT before an error response; minimum 3.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  CPU offers a command.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_write  input  1  0 = read, 1 = write.
- cmd_addr  input  16  target address.
- cmd_wdata  input  16  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse per completed command.
- rsp_write  output  1  type of the completed command.
- rsp_rdata  output  16  read data; 0 for writes and errors.
- rsp_error  output  1  1 when the command timed out.
- busy  output  1  high when the FIFO is non-empty or the state is not IDLE.
- request  output  1  request pulse to the memory controller.
- request_type  output  1  0 = read, 1 = write.
- request_address  output  16  memory address.
- data_out  output  16  write data to memory.
- memory_in  input  16  read data from the memory controller.
- memory_ready  input  1  read completion flag.
- write_complete  input  1  write completion flag.

Behaviour:
- Reset (asynchronous, any state):
  - FIFO emptied; state = IDLE; timer = 0.
  - request = 0, request_type = 0, request_address = 0, data_out = 0.
  - rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_error = 0.
  - busy = 0; cmd_ready = 1 once reset deasserts.
  - A memory operation in flight at reset is abandoned. Its completion flag is ignored because IDLE never samples the flags.
- FIFO:
  - Push on cmd_valid && cmd_ready, storing {write, addr, wdata}.
  - Pop only in IDLE.
  - When full, cmd_ready = 0 even if a pop occurs in the same cycle; no push-through.
  - Pointers wrap modulo CMD_DEPTH. An occupancy counter distinguishes full from empty.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head; load request_type, request_address and data_out; set request <= 1; go to ISSUE. Otherwise hold request = 0.
  - ISSUE: request is high for exactly this one cycle. Set request <= 0, timer <= 0, go to WAIT. The memory controller latches the command on this edge and clears its flags.
  - WAIT:
    - request stays 0; request_address, data_out and request_type stay stable.
    - Completion is memory_ready when request_type = 0, or write_complete when request_type = 1. The flag of the other type is ignored.
    - On completion: rsp_valid <= 1, rsp_write <= request_type, rsp_rdata <= (read ? memory_in : 0), rsp_error <= 0, go to IDLE.
    - Otherwise timer increments. If timer == TIMEOUT_CYCLES-1 with no completion: rsp_valid <= 1, rsp_error <= 1, rsp_rdata <= 0, go to IDLE.
    - Completion and timeout in the same cycle: completion wins.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_write, rsp_rdata and rsp_error hold their values until the next response.
- Latency and throughput:
  - Command accepted at edge E0 → request high after E1 → flag rises after E3 → rsp_valid high after E4.
  - Back-to-back commands therefore complete one every 4 cycles: IDLE, ISSUE, WAIT, WAIT.
- request never stays high for two consecutive cycles. A held request would re-trigger the controller.
- Flags raised while not in WAIT (stale or late after a timeout) have no effect.

Test Plan:
- Reset, then push a write of 0xBEEF to 0x0010, then a read of 0x0010 → request pulses 1 cycle each, exactly 4 cycles apart. First response: rsp_valid with rsp_write = 1, rsp_error = 0. Second response: rsp_rdata = 0xBEEF, rsp_write = 0, arriving 4 cycles after the first.
- Push 4 commands in 4 consecutive cycles (CMD_DEPTH = 4) while the FSM drains → cmd_ready stays high. Push 6 commands with memory stalled → cmd_ready drops when 4 are queued. All accepted commands respond in order; none is lost or duplicated.
- Memory model never raises its flag on a read → rsp_valid with rsp_error = 1 and rsp_rdata = 0 after TIMEOUT_CYCLES in WAIT. A late memory_ready afterwards produces no response. The next queued command completes normally.
- Read pending while the model asserts write_complete instead → ignored; stays in WAIT. Then memory_ready with memory_in = 0x1234 → rsp_rdata = 0x1234.
- Assert reset while in WAIT with 2 commands queued → all outputs 0 immediately (asynchronously). busy = 0, and no response appears after reset release.
- Completion flag asserted in the exact cycle the timer expires → normal response with rsp_error = 0.
